shf_arb_seq: RTL and testbench
==============================

Name: shf_arb_seq

Overview:
- Shares the single shifter unit between two requesters (program sequencer port 0, multifunction/compute port 1).
- Round-robin arbitration and request/grant handshake.
- Sequences the shifter's registered-input timing (ps_shf_en pulse, result valid combinationally next cycle) and returns a registered result plus flags with a one-cycle response strobe.
- Sits between the requesters and the shifter's ps_shf_*/xb_* interface.

Parameters:
- DATASIZE, 16, datapath width; must match the shifter.
- CNTW, 5, width of the leading-bit count and exponent fields.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_vld  in  1  port 0 request; held until gnt0
- req0_cls  in  2  port 0 shifter class (00 ashift, 01 rot, 10 clz, 11 clo)
- req0_norm  in  1  port 0 normalise op (used only with SHF_NORM_EN)
- req0_x  in  DATASIZE  port 0 Rx operand
- req0_y  in  DATASIZE  port 0 Ry operand
- gnt0  out  1  port 0 accept strobe
- req1_vld, req1_cls, req1_norm, req1_x, req1_y, gnt1: same as port 0, for port 1
- rsp_vld  out  1  result strobe, one cycle
- rsp_id  out  1  owner of result
- rsp_dt  out  DATASIZE  result
- rsp_sv  out  1  overflow flag
- rsp_sz  out  1  zero flag
- rsp_exp  out  CNTW  normalise shift amount
- busy  out  1  high in every state except IDLE
- ps_shf_en  out  1  shifter enable
- ps_shf_cls  out  2  shifter class
- xb_dtx  out  DATASIZE  shifter Rx
- xb_dty  out  DATASIZE  shifter Ry
- shf_xb_dt  in  DATASIZE  shifter result
- shf_ps_sv  in  1  shifter overflow flag
- shf_ps_sz  in  1  shifter zero flag

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - gnt0, gnt1, rsp_vld, ps_shf_en, busy = 0.
  - rsp_dt, rsp_exp, xb_dtx, xb_dty = 0; ps_shf_cls=00; rsp_id, rsp_sv, rsp_sz = 0.
  - last_id=1, so port 0 wins the first tie.
  - An in-flight op is discarded; no rsp_vld is produced for it.
- States: IDLE, ISSUE, CAPT, RESP, plus ISSUE2 and CAPT2 (SHF_NORM_EN only).
- IDLE:
  - Any req_vld causes gnt for the winner, combinational in the same cycle.
  - Winner's cls, norm, x and y are latched; owner and last_id are updated; go to ISSUE.
  - With both requesting, the winner is the port != last_id.
  - Only one gnt is ever high.
- ISSUE:
  - ps_shf_en=1 for exactly one cycle; ps_shf_cls, xb_dtx, xb_dty driven from the latch.
  - xb_dty is driven even for cls 1x. The shifter ignores it then but keeps its old ip2.
  - Go to CAPT.
- CAPT:
  - ps_shf_en=0.
  - shf_xb_dt, shf_ps_sv and shf_ps_sz are registered into the result regs at the clock edge.
  - Go to RESP (or ISSUE2 per Optional Feature).
- RESP:
  - rsp_vld=1 for one cycle with rsp_id=owner; rsp_dt, rsp_sv and rsp_sz are stable.
  - Go to IDLE.
  - rsp_* data regs hold until the next CAPT.
- Timing:
  - gnt (cycle 0) to ps_shf_en (cycle 1) to rsp_vld (cycle 3).
  - Plain op occupancy is 4 cycles; a new gnt is possible in the cycle after RESP.
  - No gnt is asserted while busy; requests remain pending.
- ps_shf_en is never asserted outside ISSUE/ISSUE2.
- A request deasserted before gnt is simply not served (requesters must not do this; no error).
- rsp_exp=0 for all non-normalise ops.

Optional Feature:
- Macro: SHF_NORM_EN.
- Defined, and the latched norm=1:
  - Pass 1 issues cls = x[15] ? 2'b11 : 2'b10 (leading-sign count).
  - In CAPT, c = shf_xb_dt[4:0].
  - If c==16 (all-zero or all-one x): result dt=x, sv=0, sz=(x==0), rsp_exp=0; go to RESP.
  - If c==1: already normalised; dt=x, sv=0, sz=0, rsp_exp=0; go to RESP.
  - Otherwise go to ISSUE2: cls=00, xb_dtx=x, xb_dty=c-1 (zero-extended).
  - CAPT2 then captures dt, with sv forced to 0, sz from the shifter, and rsp_exp=c-1; go to RESP.
  - Normalise latency: gnt to rsp_vld is 5 cycles.
- Not defined: req*_norm are ignored, ISSUE2/CAPT2 do not exist, and rsp_exp is tied to 0.

Decomposition:
- Shared package shf_pkg:
  - Class constants: SHF_ASHIFT=2'b00, SHF_ROT=2'b01, SHF_CLZ=2'b10, SHF_CLO=2'b11.
  - State encoding constants.
  - SHF_ALLCNT=5'd16.
- One sub-module, shf_rr_arb2: 2-way round-robin picker (req0, req1, last_id -> gnt0, gnt1, win_id). It is purely combinational and reusable for other shared units.

Test Plan:
- Port 0 sends cls=00, x=16'hF000, y=16'hFFFC -> gnt0 at c0, ps_shf_en at c1, rsp_vld at c3 with rsp_dt=16'hFF00, sv=0, sz=0, id=0.
- Port 1 sends cls=01, x=16'hC000, y=16'h0002 -> rsp_dt=16'h0003, sv=0, sz=0, id=1.
- Port 0 sends cls=10, x=16'h0000 -> rsp_dt=16'h0010, sv=1, sz=0.
- Both ports request continuously from reset -> grants alternate 0,1,0,1; exactly one gnt per 4 cycles; no request starved.
- With SHF_NORM_EN, norm=1, x=16'h0300 -> pass 1 cls=10 gives count 6; pass 2 cls=00, y=5; rsp_dt=16'h6000, rsp_exp=5, sv=0, rsp_vld 5 cycles after gnt.
- rst_n pulsed low in CAPT -> all outputs return to reset values immediately, no rsp_vld, and the next tie grants port 0.

Source files
------------

// File: rtl/shf_pkg.sv
// Shared constants for the shifter arbiter/sequencer slice.
// Shifter classes, sequencer state encoding and the all-bits count.
package shf_pkg;

  localparam logic [1:0] SHF_ASHIFT = 2'b00;
  localparam logic [1:0] SHF_ROT    = 2'b01;
  localparam logic [1:0] SHF_CLZ    = 2'b10;
  localparam logic [1:0] SHF_CLO    = 2'b11;

  localparam logic [4:0] SHF_ALLCNT = 5'd16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_CAPT   = 3'd2,
    ST_RESP   = 3'd3,
    ST_ISSUE2 = 3'd4,
    ST_CAPT2  = 3'd5
  } state_t;

endpackage

// File: rtl/shf_rr_arb2.sv
// Two-way round-robin picker, purely combinational.
// On a tie the port that did not win last time is granted.
module shf_rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_id,
  output logic gnt0,
  output logic gnt1,
  output logic win_id
);

  assign gnt0   = req0 & (~req1 | last_id);
  assign gnt1   = req1 & (~req0 | ~last_id);
  assign win_id = gnt1;

endmodule

// File: rtl/shf_arb_seq.sv
// Shares one registered-input shifter between two requesters.
// Optional normalise sequencing when SHF_NORM_EN is defined.
module shf_arb_seq
  import shf_pkg::*;
#(
  parameter int DATASIZE = 16,
  parameter int CNTW     = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_vld,
  input  logic [1:0]          req0_cls,
  input  logic                req0_norm,
  input  logic [DATASIZE-1:0] req0_x,
  input  logic [DATASIZE-1:0] req0_y,
  output logic                gnt0,
  input  logic                req1_vld,
  input  logic [1:0]          req1_cls,
  input  logic                req1_norm,
  input  logic [DATASIZE-1:0] req1_x,
  input  logic [DATASIZE-1:0] req1_y,
  output logic                gnt1,
  output logic                rsp_vld,
  output logic                rsp_id,
  output logic [DATASIZE-1:0] rsp_dt,
  output logic                rsp_sv,
  output logic                rsp_sz,
  output logic [CNTW-1:0]     rsp_exp,
  output logic                busy,
  output logic                ps_shf_en,
  output logic [1:0]          ps_shf_cls,
  output logic [DATASIZE-1:0] xb_dtx,
  output logic [DATASIZE-1:0] xb_dty,
  input  logic [DATASIZE-1:0] shf_xb_dt,
  input  logic                shf_ps_sv,
  input  logic                shf_ps_sz
);

  state_t state;
  logic   last_id;
  logic   owner;
  logic   idle;
  logic   a_gnt0;
  logic   a_gnt1;
  logic   a_win;

  logic [1:0]          w_cls;
  logic [1:0]          w_pcls;
  logic [DATASIZE-1:0] w_x;
  logic [DATASIZE-1:0] w_y;

  shf_rr_arb2 u_arb (
    .req0    (req0_vld),
    .req1    (req1_vld),
    .last_id (last_id),
    .gnt0    (a_gnt0),
    .gnt1    (a_gnt1),
    .win_id  (a_win)
  );

  assign idle = (state == ST_IDLE);
  assign busy = ~idle;
  // Grants are gated by reset so none escapes while rst_n is low
  assign gnt0 = rst_n & idle & a_gnt0;
  assign gnt1 = rst_n & idle & a_gnt1;

  assign w_cls = a_win ? req1_cls : req0_cls;
  assign w_x   = a_win ? req1_x   : req0_x;
  assign w_y   = a_win ? req1_y   : req0_y;

`ifdef SHF_NORM_EN
  logic            w_norm;
  logic            l_norm;
  logic            do_pass2;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] l_exp;
  logic [CNTW-1:0] exp_q;

  assign w_norm = a_win ? req1_norm : req0_norm;
  // Pass 1 of a normalise counts leading sign bits
  assign w_pcls = !w_norm ? w_cls :
                  w_x[DATASIZE-1] ? SHF_CLO : SHF_CLZ;
  assign cnt      = shf_xb_dt[CNTW-1:0];
  assign do_pass2 = l_norm &&
                    (cnt != CNTW'(1)) &&
                    (cnt != CNTW'(SHF_ALLCNT));
  assign rsp_exp  = exp_q;
`else
  logic unused_norm;
  assign unused_norm = req0_norm ^ req1_norm;
  assign w_pcls      = w_cls;
  assign rsp_exp     = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_id    <= 1'b1;
      owner      <= 1'b0;
      ps_shf_en  <= 1'b0;
      ps_shf_cls <= SHF_ASHIFT;
      xb_dtx     <= '0;
      xb_dty     <= '0;
      rsp_vld    <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_dt     <= '0;
      rsp_sv     <= 1'b0;
      rsp_sz     <= 1'b0;
`ifdef SHF_NORM_EN
      l_norm     <= 1'b0;
      l_exp      <= '0;
      exp_q      <= '0;
`endif
    end else begin
      ps_shf_en <= 1'b0;
      rsp_vld   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (a_gnt0 | a_gnt1) begin
            owner      <= a_win;
            last_id    <= a_win;
            ps_shf_en  <= 1'b1;
            ps_shf_cls <= w_pcls;
            xb_dtx     <= w_x;
            xb_dty     <= w_y;
`ifdef SHF_NORM_EN
            l_norm     <= w_norm;
`endif
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_CAPT;
        ST_CAPT: begin
`ifdef SHF_NORM_EN
          if (do_pass2) begin
            ps_shf_en  <= 1'b1;
            ps_shf_cls <= SHF_ASHIFT;
            xb_dty     <= DATASIZE'(cnt - CNTW'(1));
            l_exp      <= cnt - CNTW'(1);
            state      <= ST_ISSUE2;
          end else begin
            rsp_vld <= 1'b1;
            rsp_id  <= owner;
            exp_q   <= '0;
            state   <= ST_RESP;
            // Zero/sign-only or already normalised: x passes through
            if (l_norm) begin
              rsp_dt <= xb_dtx;
              rsp_sv <= 1'b0;
              rsp_sz <= (xb_dtx == '0);
            end else begin
              rsp_dt <= shf_xb_dt;
              rsp_sv <= shf_ps_sv;
              rsp_sz <= shf_ps_sz;
            end
          end
`else
          rsp_vld <= 1'b1;
          rsp_id  <= owner;
          rsp_dt  <= shf_xb_dt;
          rsp_sv  <= shf_ps_sv;
          rsp_sz  <= shf_ps_sz;
          state   <= ST_RESP;
`endif
        end
        ST_RESP: state <= ST_IDLE;
`ifdef SHF_NORM_EN
        ST_ISSUE2: state <= ST_CAPT2;
        ST_CAPT2: begin
          rsp_vld <= 1'b1;
          rsp_id  <= owner;
          rsp_dt  <= shf_xb_dt;
          rsp_sv  <= 1'b0;
          rsp_sz  <= shf_ps_sz;
          exp_q   <= l_exp;
          state   <= ST_RESP;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shf_arb_seq.sv
// Directed bench for shf_arb_seq with a cycle-accurate shifter stub.
// Build with +define+SHF_NORM_EN to cover the normalise path.
module tb_shf_arb_seq;

  logic        clk;
  logic        rst_n;
  logic        req0_vld, req1_vld;
  logic [1:0]  req0_cls, req1_cls;
  logic        req0_norm, req1_norm;
  logic [15:0] req0_x, req0_y, req1_x, req1_y;
  logic        gnt0, gnt1;
  logic        rsp_vld, rsp_id, rsp_sv, rsp_sz;
  logic [15:0] rsp_dt;
  logic [4:0]  rsp_exp;
  logic        busy, ps_shf_en;
  logic [1:0]  ps_shf_cls;
  logic [15:0] xb_dtx, xb_dty;
  logic [15:0] shf_xb_dt;
  logic        shf_ps_sv, shf_ps_sz;

  int checks = 0;
  int errors = 0;

  logic [15:0] sh_dt, cnt_dt;
  logic        sh_sv, sh_sz, cnt_sv, cnt_sz;
  logic [1:0]  iss_cls [2];
  logic [15:0] iss_x [2];
  logic [15:0] iss_y [2];

  shf_arb_seq #(.DATASIZE(16), .CNTW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_vld(req0_vld), .req0_cls(req0_cls),
    .req0_norm(req0_norm), .req0_x(req0_x),
    .req0_y(req0_y), .gnt0(gnt0),
    .req1_vld(req1_vld), .req1_cls(req1_cls),
    .req1_norm(req1_norm), .req1_x(req1_x),
    .req1_y(req1_y), .gnt1(gnt1),
    .rsp_vld(rsp_vld), .rsp_id(rsp_id),
    .rsp_dt(rsp_dt), .rsp_sv(rsp_sv),
    .rsp_sz(rsp_sz), .rsp_exp(rsp_exp),
    .busy(busy), .ps_shf_en(ps_shf_en),
    .ps_shf_cls(ps_shf_cls),
    .xb_dtx(xb_dtx), .xb_dty(xb_dty),
    .shf_xb_dt(shf_xb_dt),
    .shf_ps_sv(shf_ps_sv), .shf_ps_sz(shf_ps_sz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shifter stub: result valid only in the cycle after ps_shf_en
  always @(posedge clk) begin
    if (ps_shf_en === 1'b1) begin
      if (ps_shf_cls[1]) begin
        shf_xb_dt <= cnt_dt;
        shf_ps_sv <= cnt_sv;
        shf_ps_sz <= cnt_sz;
      end else begin
        shf_xb_dt <= sh_dt;
        shf_ps_sv <= sh_sv;
        shf_ps_sz <= sh_sz;
      end
    end else begin
      shf_xb_dt <= 16'hDEAD;
      shf_ps_sv <= 1'b1;
      shf_ps_sz <= 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic run_op(
    input  logic        p,
    input  logic [1:0]  cls,
    input  logic        norm,
    input  logic [15:0] x,
    input  logic [15:0] y,
    output int          g_wait,
    output int          en_cnt,
    output int          en_cyc,
    output int          rsp_cyc
  );
    g_wait  = -1;
    en_cnt  = 0;
    en_cyc  = -1;
    rsp_cyc = -1;
    @(negedge clk);
    if (p) begin
      req1_vld = 1'b1; req1_cls = cls;
      req1_norm = norm; req1_x = x; req1_y = y;
    end else begin
      req0_vld = 1'b1; req0_cls = cls;
      req0_norm = norm; req0_x = x; req0_y = y;
    end
    #1;
    for (int k = 0; k < 16; k++) begin
      if ((p ? gnt1 : gnt0) === 1'b1) begin
        g_wait = k;
        break;
      end
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    req0_vld = 1'b0;
    req1_vld = 1'b0;
    if (g_wait < 0) return;
    for (int c = 1; c < 12; c++) begin
      #1;
      if (ps_shf_en === 1'b1) begin
        if (en_cnt < 2) begin
          iss_cls[en_cnt] = ps_shf_cls;
          iss_x[en_cnt]   = xb_dtx;
          iss_y[en_cnt]   = xb_dty;
        end
        if (en_cyc < 0) en_cyc = c;
        en_cnt++;
      end
      if (rsp_vld === 1'b1) begin
        rsp_cyc = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req0_vld = 1'b1; req1_vld = 1'b0;
    req0_cls = 2'b00; req1_cls = 2'b00;
    req0_norm = 1'b0; req1_norm = 1'b0;
    req0_x = '0; req0_y = '0;
    req1_x = '0; req1_y = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_gnt got %b%b want 00", gnt0, gnt1);
    end
    checks++;
    if ({busy, ps_shf_en, rsp_vld} !== 3'b000) begin
      errors++;
      $display("FAIL rst_ctl got %b want 000",
               {busy, ps_shf_en, rsp_vld});
    end
    checks++;
    if ({rsp_dt, xb_dtx, xb_dty} !== 48'h0) begin
      errors++;
      $display("FAIL rst_data got %h want 0",
               {rsp_dt, xb_dtx, xb_dty});
    end
    checks++;
    if ({ps_shf_cls, rsp_id, rsp_sv, rsp_sz, rsp_exp} !== 10'h0) begin
      errors++;
      $display("FAIL rst_misc got %h want 0",
               {ps_shf_cls, rsp_id, rsp_sv, rsp_sz, rsp_exp});
    end
    req0_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_busy got %b want 0", busy);
    end
  endtask

  task automatic test_ashift;
    int gw, ec, ey, ry;
    sh_dt = 16'hFF00; sh_sv = 1'b0; sh_sz = 1'b0;
    run_op(1'b0, 2'b00, 1'b0, 16'hF000, 16'hFFFC, gw, ec, ey, ry);
    checks++;
    if (gw !== 0 || ey !== 1 || ry !== 3 || ec !== 1) begin
      errors++;
      $display("FAIL ash_timing got g%0d e%0d r%0d n%0d want g0 e1 r3 n1",
               gw, ey, ry, ec);
    end
    checks++;
    if ({iss_cls[0], iss_x[0], iss_y[0]} !== {2'b00, 16'hF000, 16'hFFFC}) begin
      errors++;
      $display("FAIL ash_issue got %h %h %h want 0 f000 fffc",
               iss_cls[0], iss_x[0], iss_y[0]);
    end
    checks++;
    if (rsp_dt !== 16'hFF00 || rsp_sv !== 1'b0 || rsp_sz !== 1'b0) begin
      errors++;
      $display("FAIL ash_rsp got %h sv%b sz%b want ff00 sv0 sz0",
               rsp_dt, rsp_sv, rsp_sz);
    end
    checks++;
    if (rsp_id !== 1'b0 || rsp_exp !== 5'd0) begin
      errors++;
      $display("FAIL ash_id got %b exp %0d want 0 exp 0", rsp_id, rsp_exp);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rsp_vld !== 1'b0 || busy !== 1'b0 || rsp_dt !== 16'hFF00) begin
      errors++;
      $display("FAIL ash_after got v%b b%b %h want v0 b0 ff00",
               rsp_vld, busy, rsp_dt);
    end
  endtask

  task automatic test_rot;
    int gw, ec, ey, ry;
    sh_dt = 16'h0003; sh_sv = 1'b0; sh_sz = 1'b0;
    run_op(1'b1, 2'b01, 1'b0, 16'hC000, 16'h0002, gw, ec, ey, ry);
    checks++;
    if (gw !== 0 || ry !== 3 || iss_cls[0] !== 2'b01) begin
      errors++;
      $display("FAIL rot_timing got g%0d r%0d cls%b want g0 r3 cls01",
               gw, ry, iss_cls[0]);
    end
    checks++;
    if (rsp_dt !== 16'h0003 || rsp_id !== 1'b1 || rsp_sv !== 1'b0 ||
        rsp_sz !== 1'b0) begin
      errors++;
      $display("FAIL rot_rsp got %h id%b sv%b sz%b want 0003 id1 sv0 sz0",
               rsp_dt, rsp_id, rsp_sv, rsp_sz);
    end
  endtask

  task automatic test_clz;
    int gw, ec, ey, ry;
    cnt_dt = 16'h0010; cnt_sv = 1'b1; cnt_sz = 1'b0;
    run_op(1'b0, 2'b10, 1'b0, 16'h0000, 16'h1234, gw, ec, ey, ry);
    checks++;
    if (ry !== 3 || iss_cls[0] !== 2'b10 || iss_y[0] !== 16'h1234) begin
      errors++;
      $display("FAIL clz_issue got r%0d cls%b y%h want r3 cls10 y1234",
               ry, iss_cls[0], iss_y[0]);
    end
    checks++;
    if (rsp_dt !== 16'h0010 || rsp_sv !== 1'b1 || rsp_sz !== 1'b0 ||
        rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL clz_rsp got %h sv%b sz%b id%b want 0010 sv1 sz0 id0",
               rsp_dt, rsp_sv, rsp_sz, rsp_id);
    end
  endtask

`ifdef SHF_NORM_EN
  task automatic test_norm;
    int gw, ec, ey, ry;
    cnt_dt = 16'h0006; cnt_sv = 1'b0; cnt_sz = 1'b0;
    sh_dt = 16'h6000; sh_sv = 1'b1; sh_sz = 1'b0;
    run_op(1'b0, 2'b00, 1'b1, 16'h0300, 16'h0000, gw, ec, ey, ry);
    checks++;
    if (gw !== 0 || ry !== 5 || ec !== 2) begin
      errors++;
      $display("FAIL norm_timing got g%0d r%0d n%0d want g0 r5 n2",
               gw, ry, ec);
    end
    checks++;
    if (iss_cls[0] !== 2'b10 || iss_cls[1] !== 2'b00 ||
        iss_x[1] !== 16'h0300 || iss_y[1] !== 16'h0005) begin
      errors++;
      $display("FAIL norm_issue got %b %b %h %h want 10 00 0300 0005",
               iss_cls[0], iss_cls[1], iss_x[1], iss_y[1]);
    end
    checks++;
    if (rsp_dt !== 16'h6000 || rsp_exp !== 5'd5 || rsp_sv !== 1'b0) begin
      errors++;
      $display("FAIL norm_rsp got %h exp%0d sv%b want 6000 exp5 sv0",
               rsp_dt, rsp_exp, rsp_sv);
    end
    // All-zero operand: count of 16 short-circuits to RESP
    cnt_dt = 16'h0010; cnt_sz = 1'b0;
    run_op(1'b1, 2'b00, 1'b1, 16'h0000, 16'h0000, gw, ec, ey, ry);
    checks++;
    if (ry !== 3 || ec !== 1 || rsp_dt !== 16'h0000 || rsp_sz !== 1'b1 ||
        rsp_sv !== 1'b0 || rsp_exp !== 5'd0) begin
      errors++;
      $display("FAIL norm_zero got r%0d n%0d %h sz%b sv%b e%0d want r3 n1 0 sz1 sv0 e0",
               ry, ec, rsp_dt, rsp_sz, rsp_sv, rsp_exp);
    end
    // Negative already-normalised operand: count of 1
    cnt_dt = 16'h0001; cnt_sz = 1'b1;
    run_op(1'b0, 2'b00, 1'b1, 16'hA000, 16'h0000, gw, ec, ey, ry);
    checks++;
    if (ry !== 3 || iss_cls[0] !== 2'b11 || rsp_dt !== 16'hA000 ||
        rsp_sz !== 1'b0 || rsp_exp !== 5'd0) begin
      errors++;
      $display("FAIL norm_one got r%0d cls%b %h sz%b e%0d want r3 cls11 a000 sz0 e0",
               ry, iss_cls[0], rsp_dt, rsp_sz, rsp_exp);
    end
  endtask
`else
  task automatic test_norm;
    int gw, ec, ey, ry;
    sh_dt = 16'h6000; sh_sv = 1'b1; sh_sz = 1'b0;
    run_op(1'b0, 2'b00, 1'b1, 16'h0300, 16'h0005, gw, ec, ey, ry);
    checks++;
    if (ry !== 3 || ec !== 1 || iss_cls[0] !== 2'b00) begin
      errors++;
      $display("FAIL nonorm_timing got r%0d n%0d cls%b want r3 n1 cls00",
               ry, ec, iss_cls[0]);
    end
    checks++;
    if (rsp_dt !== 16'h6000 || rsp_sv !== 1'b1 || rsp_exp !== 5'd0) begin
      errors++;
      $display("FAIL nonorm_rsp got %h sv%b e%0d want 6000 sv1 e0",
               rsp_dt, rsp_sv, rsp_exp);
    end
  endtask
`endif

  task automatic test_back_to_back;
    int gcnt, both;
    int gid [4];
    int gcy [4];
    gcnt = 0;
    both = 0;
    sh_dt = 16'h0003; sh_sv = 1'b0; sh_sz = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req0_vld = 1'b1; req0_cls = 2'b01; req0_norm = 1'b0;
    req1_vld = 1'b1; req1_cls = 2'b01; req1_norm = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (gnt0 === 1'b1 && gnt1 === 1'b1) both++;
      if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
        if (gcnt < 4) begin
          gid[gcnt] = (gnt1 === 1'b1) ? 1 : 0;
          gcy[gcnt] = i;
        end
        gcnt++;
      end
      @(negedge clk);
    end
    req0_vld = 1'b0;
    req1_vld = 1'b0;
    checks++;
    if (both !== 0 || gcnt !== 4) begin
      errors++;
      $display("FAIL b2b_count got both%0d n%0d want both0 n4", both, gcnt);
    end
    if (gcnt == 4) begin
      checks++;
      if (gid[0] !== 0 || gid[1] !== 1 || gid[2] !== 0 || gid[3] !== 1) begin
        errors++;
        $display("FAIL b2b_order got %0d%0d%0d%0d want 0101",
                 gid[0], gid[1], gid[2], gid[3]);
      end
      checks++;
      if (gcy[0] !== 0 || gcy[1] !== 4 || gcy[2] !== 8 || gcy[3] !== 12) begin
        errors++;
        $display("FAIL b2b_cycles got %0d %0d %0d %0d want 0 4 8 12",
                 gcy[0], gcy[1], gcy[2], gcy[3]);
      end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_capt;
    int nvld;
    nvld = 0;
    @(negedge clk);
    req0_vld = 1'b1; req0_cls = 2'b00; req0_norm = 1'b0;
    req0_x = 16'h1234; req0_y = 16'h0001;
    #1;
    checks++;
    if (gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL rc_gnt got %b want 1", gnt0);
    end
    @(negedge clk);
    req0_vld = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, ps_shf_en, rsp_vld, ps_shf_cls, rsp_id} !== 6'b0) begin
      errors++;
      $display("FAIL rc_ctl got %b want 000000",
               {busy, ps_shf_en, rsp_vld, ps_shf_cls, rsp_id});
    end
    checks++;
    if ({rsp_dt, xb_dtx, xb_dty} !== 48'h0) begin
      errors++;
      $display("FAIL rc_data got %h want 0", {rsp_dt, xb_dtx, xb_dty});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (rsp_vld === 1'b1) nvld++;
      @(negedge clk);
    end
    checks++;
    if (nvld !== 0) begin
      errors++;
      $display("FAIL rc_norsp got %0d want 0", nvld);
    end
    req0_vld = 1'b1;
    req1_vld = 1'b1;
    #1;
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL rc_tie got %b%b want 10", gnt0, gnt1);
    end
    @(negedge clk);
    req0_vld = 1'b0;
    req1_vld = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    sh_dt = '0; sh_sv = 1'b0; sh_sz = 1'b0;
    cnt_dt = '0; cnt_sv = 1'b0; cnt_sz = 1'b0;
    test_reset();
    test_ashift();
    test_rot();
    test_clz();
    test_norm();
    test_back_to_back();
    test_reset_capt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
